// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job scheduler.
// Holds the controller state encoding, default geometry and the helper that sizes
// the iteration counter so it can hold MAX_ITER itself.
package gcd_pkg;

  localparam int unsigned DefW       = 16;
  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefMaxIter = 65535;

  // Counter must represent MAX_ITER, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned max_iter);
    return $clog2(max_iter + 1);
  endfunction

  localparam int unsigned DefCntW = $clog2(DefMaxIter + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StIter,
    StResp
  } state_e;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Round-robin arbiter for the GCD job scheduler.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   enable      - arbitration allowed this cycle (controller idle)
//   req_valid   - per-requester request
//   grant       - one-hot grant, combinational
//   grant_id    - index of the granted requester
//   accept      - a grant is issued this cycle
// The priority pointer names the requester with highest priority; it moves to
// one past the winner on every accepted grant.
module gcd_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            accept
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic           found;

  // Scan from ptr upward, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (enable && !found && req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_id        = scan_idx;
        found           = 1'b1;
      end
    end
  end

  assign accept = found;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gcd_job_scheduler.sv
// GCD job scheduler: shares one subtract-based GCD datapath between NREQ
// requesters.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req_valid/req_a/req_b   - per-requester job request and packed operands
//   req_ready               - one-hot, one-cycle acceptance pulse
//   resp_valid/resp_ready   - result handshake
//   resp_id/result/err      - owner id, GCD value (0 on error), limit-hit flag
//   busy                    - a job is in progress
//   ldA, ldB, sel1, sel2,
//   sel_in, data_in         - datapath controls and load value
//   lt, gt, eq, a_val       - datapath compare flags and A register value
// A zero operand skips the datapath entirely (gcd(x,0)=x). Otherwise both
// datapath registers are loaded, then the subtract loop runs until eq or until
// MAX_ITER subtracts have been issued without reaching eq.
module gcd_job_scheduler
  import gcd_pkg::*;
#(
  parameter int unsigned W        = DefW,
  parameter int unsigned NREQ     = DefNreq,
  parameter int unsigned IDW      = $clog2(NREQ),
  parameter int unsigned MAX_ITER = DefMaxIter
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_result,
  output logic              resp_err,
  output logic              busy,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic [W-1:0]      data_in,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  input  logic [W-1:0]      a_val
);

  localparam int unsigned CntW = cnt_width(MAX_ITER);

  state_e state_q, state_d;

  logic [W-1:0]    a_q, b_q, res_q;
  logic [IDW-1:0]  id_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            accept;
  logic            arb_enable;
  logic [W-1:0]    sel_a, sel_b;
  logic            zero_op;
  logic            at_limit;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign arb_enable = (state_q == StIdle) && rst_n;

  gcd_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (arb_enable),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .accept    (accept)
  );

  // Winner's operands, selected with the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  assign zero_op  = (sel_a == '0) || (sel_b == '0);
  assign at_limit = (cnt_q == CntW'(MAX_ITER));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = zero_op ? StResp : StLoadA;
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StIter;
      StIter: begin
        if (eq || at_limit) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; ITER controls are Mealy on the compare flags.
  always_comb begin
    ldA        = 1'b0;
    ldB        = 1'b0;
    sel1       = 1'b0;
    sel2       = 1'b0;
    sel_in     = 1'b0;
    data_in    = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      StLoadA: begin
        sel_in  = 1'b1;
        data_in = a_q;
        ldA     = 1'b1;
      end
      StLoadB: begin
        sel_in  = 1'b1;
        data_in = b_q;
        ldB     = 1'b1;
      end
      StIter: begin
        // At the limit no further subtract is issued; the job aborts instead.
        if (!eq && !at_limit) begin
          if (lt) begin
            sel1 = 1'b1;
            ldB  = 1'b1;
          end else if (gt) begin
            sel2 = 1'b1;
            ldA  = 1'b1;
          end
        end
      end
      StResp:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign req_ready   = grant;
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign resp_err    = err_q;

  // Job context: operands, owner, subtract count and the pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= grant_id;
            cnt_q <= '0;
            res_q <= zero_op ? (sel_a | sel_b) : '0;
            err_q <= 1'b0;
          end
        end
        StIter: begin
          if (eq) begin
            res_q <= a_val;
            err_q <= 1'b0;
          end else if (at_limit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else if (lt || gt) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Self-checking bench for gcd_job_scheduler with a behavioural GCD datapath
// attached and a reference model computing Euclid-by-subtraction directly.
module tb_gcd_job_scheduler;

  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int MAXI = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid, resp_ready, resp_err, busy;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_result, data_in, a_val;
  logic              ldA, ldB, sel1, sel2, sel_in, lt, gt, eq;

  logic [W-1:0] op_a [NREQ];
  logic [W-1:0] op_b [NREQ];
  logic [W-1:0] dp_a = 16'h0001;
  logic [W-1:0] dp_b = 16'h0001;

  int vectors = 0, miscompares = 0;
  int cyc = 0, tot_sub = 0, tot_ld = 0, both_ld = 0, tb_ptr = 0;

  gcd_job_scheduler #(
    .W        (W),
    .NREQ     (NREQ),
    .IDW      (IDW),
    .MAX_ITER (MAXI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy),
    .ldA         (ldA),
    .ldB         (ldB),
    .sel1        (sel1),
    .sel2        (sel2),
    .sel_in      (sel_in),
    .data_in     (data_in),
    .lt          (lt),
    .gt          (gt),
    .eq          (eq),
    .a_val       (a_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  end

  // Datapath: A/B registers with load-or-subtract muxing.
  always @(posedge clk) begin
    if (ldA) dp_a <= sel_in ? data_in : dp_a - dp_b;
    if (ldB) dp_b <= sel_in ? data_in : dp_b - dp_a;
  end
  assign lt    = dp_a < dp_b;
  assign gt    = dp_a > dp_b;
  assign eq    = dp_a == dp_b;
  assign a_val = dp_a;

  always @(negedge clk) begin
    if (ldA || ldB) tot_ld++;
    if ((ldA || ldB) && !sel_in) tot_sub++;
    if (ldA && ldB) both_ld++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: k = subtracts issued (-1 for zero shortcut).
  function automatic void gcd_model(input int a_in, input int b_in,
                                    output int res, output int err, output int k);
    int a, b;
    a = a_in; b = b_in; res = 0; err = 0; k = 0;
    if (a == 0 || b == 0) begin
      res = a | b;
      k   = -1;
      return;
    end
    while (a != b) begin
      if (k == MAXI) begin
        err = 1;
        res = 0;
        return;
      end
      if (a > b) a = a - b;
      else       b = b - a;
      k++;
    end
    res = a;
  endfunction

  function automatic int rr_pick();
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (tb_ptr + i) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom_range(1, 150));
  endfunction

  task automatic wait_grant(output int g);
    g = -1;
    for (int n = 0; n < 60 && g < 0; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
    end
  endtask

  // Serves one job end to end; returns at posedge+1 of the cycle after accept.
  task automatic serve_one(input int exp_g, input int stall,
                           output int got_res, output int got_err);
    int g, t, tr, res, err, k, s0, l0, lat;
    got_res = -1;
    got_err = -1;
    resp_ready = (stall == 0);
    wait_grant(g);
    check("grant_id", g, exp_g);
    if (g < 0) return;
    t = cyc;
    check("grant_onehot", $countones(req_ready), 1);
    check("busy_at_grant", busy, 0);
    gcd_model(op_a[g], op_b[g], res, err, k);
    lat = (k < 0) ? 1 : 4 + k;
    s0 = tot_sub;
    l0 = tot_ld;
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    tb_ptr = (g + 1) % NREQ;
    tr = -1;
    for (int n = 0; n < 60 && tr < 0; n++) begin
      @(negedge clk);
      check("no_ready_busy", req_ready, 0);
      if (resp_valid) tr = cyc;
    end
    check("resp_latency", tr - t, lat);
    if (tr < 0) return;
    check("resp_id", resp_id, g);
    check("resp_result", resp_result, res);
    check("resp_err", resp_err, err);
    check("subtract_count", tot_sub - s0, (k < 0) ? 0 : k);
    if (k < 0) check("zero_no_load", tot_ld - l0, 0);
    got_res = int'(resp_result);
    got_err = int'(resp_err);
    for (int n = 0; n < stall; n++) begin
      @(negedge clk);
      check("stall_valid", resp_valid, 1);
      check("stall_id", resp_id, g);
      check("stall_result", resp_result, res);
      check("stall_err", resp_err, err);
      check("stall_no_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_accept", busy, 0);
    check("valid_drop", resp_valid, 0);
  endtask

  initial begin
    int gr, ge, g, exp;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ld", {ldA, ldB, sel1, sel2, sel_in}, 0);
    check("rst_data_in", data_in, 0);
    check("rst_resp_fields", {resp_id, resp_result, resp_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 48/18: 4 subtracts, response 8 cycles after handshake.
    op_a[0] = 16'd48; op_b[0] = 16'd18; req_valid[0] = 1'b1;
    serve_one(0, 0, gr, ge);
    check("gcd_48_18", gr, 6);

    // Simultaneous requesters 1 and 3.
    op_a[1] = 16'd35; op_b[1] = 16'd14; req_valid[1] = 1'b1;
    op_a[3] = 16'd9;  op_b[3] = 16'd6;  req_valid[3] = 1'b1;
    serve_one(1, 0, gr, ge);
    check("gcd_35_14", gr, 7);
    serve_one(3, 0, gr, ge);
    check("gcd_9_6", gr, 3);

    // All four held valid: order 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = rnd_op(); op_b[i] = rnd_op(); req_valid[i] = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      serve_one(i % NREQ, 0, gr, ge);
      op_a[i % NREQ] = rnd_op(); op_b[i % NREQ] = rnd_op(); req_valid[i % NREQ] = 1'b1;
    end
    req_valid = '0;

    // Zero operand shortcut.
    op_a[2] = 16'd0;  op_b[2] = 16'd25; req_valid[2] = 1'b1;
    serve_one(2, 0, gr, ge);
    check("zero_a", gr, 25);
    op_a[2] = 16'd25; op_b[2] = 16'd0;  req_valid[2] = 1'b1;
    serve_one(2, 0, gr, ge);
    check("zero_b", gr, 25);
    op_a[2] = 16'd0;  op_b[2] = 16'd0;  req_valid[2] = 1'b1;
    serve_one(2, 0, gr, ge);
    check("zero_both", gr, 0);

    // Iteration limit.
    op_a[1] = 16'd1000; op_b[1] = 16'd1; req_valid[1] = 1'b1;
    serve_one(1, 0, gr, ge);
    check("limit_err", ge, 1);
    check("limit_result", gr, 0);

    // Backpressure with another requester waiting.
    op_a[3] = 16'd7;   op_b[3] = 16'd7;  req_valid[3] = 1'b1;
    op_a[0] = 16'd100; op_b[0] = 16'd75; req_valid[0] = 1'b1;
    exp = rr_pick();
    serve_one(exp, 5, gr, ge);
    exp = rr_pick();
    serve_one(exp, 0, gr, ge);

    // Reset in the middle of the subtract loop.
    op_a[0] = 16'd48; op_b[0] = 16'd18; req_valid[0] = 1'b1;
    wait_grant(g);
    check("rst_job_grant", g, 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_subtract", {ldA | ldB, sel_in}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ctrl", {ldA, ldB, sel1, sel2, sel_in, req_ready}, 0);
    check("midrst_data_in", data_in, 0);
    check("midrst_resp_fields", {resp_id, resp_result, resp_err}, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rst_no_resp", resp_valid, 0);
    end
    rst_n = 1'b1;
    tb_ptr = 0;
    @(posedge clk); #1;
    op_a[2] = 16'd21; op_b[2] = 16'd6; req_valid[2] = 1'b1;
    serve_one(2, 0, gr, ge);
    check("gcd_21_6", gr, 3);

    // Random traffic.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          op_a[i] = rnd_op(); op_b[i] = rnd_op(); req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if (req_valid != '0) begin
        exp = rr_pick();
        serve_one(exp, int'($urandom_range(0, 2)), gr, ge);
      end
    end
    req_valid = '0;

    check("never_both_ld", both_ld, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
